// File: rtl/mesh_term_rr_arbiter.sv
// Round-robin arbiter feeding one mesh terminal injection port from N_REQ local sources.
// Optional per-source grant statistics are enabled by defining MESH_ARB_GRANT_STATS_EN.
module mesh_term_rr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int pckg_sz = 32
`ifdef MESH_ARB_GRANT_STATS_EN
  , parameter int CNT_W = 16
`endif
  , localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           pndng_req,
  input  logic [N_REQ*pckg_sz-1:0]   data_req,
  output logic [N_REQ-1:0]           pop_req,
  output logic                       pndng_o,
  output logic [pckg_sz-1:0]         data_o,
  input  logic                       pop_i,
  output logic [IDX_W-1:0]           gnt_idx_o,
  output logic                       protocol_err
`ifdef MESH_ARB_GRANT_STATS_EN
  , output logic [N_REQ*CNT_W-1:0]   grant_cnt,
  output logic [CNT_W-1:0]           max_wait
`endif
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;

  logic               state_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   winner_s;
  logic [IDX_W-1:0]   scan_idx_s;
  logic               found_s;
  logic               load_en_s;
  logic [pckg_sz-1:0] sel_data_s;

  // Scan sources starting just after the last winner, wrapping around.
  always_comb begin
    found_s    = 1'b0;
    winner_s   = '0;
    scan_idx_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx_s = IDX_W'((int'(rr_ptr_r) + 1 + k) % N_REQ);
      if (!found_s && pndng_req[scan_idx_s]) begin
        found_s  = 1'b1;
        winner_s = scan_idx_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // A new packet may be loaded when the holding register is empty or being drained this cycle.
  always_comb begin
    load_en_s  = 1'b0;
    sel_data_s = data_req[winner_s*pckg_sz +: pckg_sz];
    if (found_s && ((state_r == ST_IDLE) || pop_i)) begin
      load_en_s = 1'b1;
    end else begin
      load_en_s = 1'b0;
    end
  end

  // Combinational pop toward the winning source, suppressed while reset is held.
  always_comb begin
    pop_req = '0;
    if (reset && load_en_s) begin
      pop_req[winner_s] = 1'b1;
    end else begin
      pop_req = '0;
    end
  end

  // Sequencer: holding register, pending flag and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      rr_ptr_r  <= IDX_W'(N_REQ - 1);
      pndng_o   <= 1'b0;
      data_o    <= '0;
      gnt_idx_o <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (load_en_s) begin
            state_r   <= ST_SEND;
            rr_ptr_r  <= winner_s;
            pndng_o   <= 1'b1;
            data_o    <= sel_data_s;
            gnt_idx_o <= winner_s;
          end
        end
        ST_SEND: begin
          if (load_en_s) begin
            rr_ptr_r  <= winner_s;
            data_o    <= sel_data_s;
            gnt_idx_o <= winner_s;
          end else if (pop_i) begin
            state_r <= ST_IDLE;
            pndng_o <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          pndng_o <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag for a router pop with nothing pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      protocol_err <= 1'b0;
    end else if (pop_i && !pndng_o) begin
      protocol_err <= 1'b1;
    end
  end

`ifdef MESH_ARB_GRANT_STATS_EN
  logic [N_REQ-1:0][CNT_W-1:0] grant_cnt_r;
  logic [N_REQ-1:0][CNT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0]            max_wait_r;
  logic [CNT_W-1:0]            wait_peak_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Per-source grant and current-wait counters, both saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt_r <= '0;
      wait_cnt_r  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (pop_req[i]) begin
          grant_cnt_r[i] <= sat_inc(grant_cnt_r[i]);
        end
        if (pndng_req[i] && !pop_req[i]) begin
          wait_cnt_r[i] <= sat_inc(wait_cnt_r[i]);
        end else begin
          wait_cnt_r[i] <= '0;
        end
      end
    end
  end

  // Largest current wait across all sources.
  always_comb begin
    wait_peak_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (wait_cnt_r[i] > wait_peak_s) begin
        wait_peak_s = wait_cnt_r[i];
      end else begin
        wait_peak_s = wait_peak_s;
      end
    end
  end

  // High-water mark of the wait counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_wait_r <= '0;
    end else if (wait_peak_s > max_wait_r) begin
      max_wait_r <= wait_peak_s;
    end
  end

  assign grant_cnt = grant_cnt_r;
  assign max_wait  = max_wait_r;
`endif

endmodule

// File: tb/tb_mesh_term_rr_arbiter.sv
// Directed self-checking bench for mesh_term_rr_arbiter (N_REQ=4, 32-bit packets).
// Covers the MESH_ARB_GRANT_STATS_EN counters when that macro is defined.
module tb_mesh_term_rr_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   pndng_req;
  logic [127:0] data_req;
  logic [3:0]   pop_req;
  logic         pndng_o;
  logic [31:0]  data_o;
  logic         pop_i;
  logic [1:0]   gnt_idx_o;
  logic         protocol_err;
`ifdef MESH_ARB_GRANT_STATS_EN
  logic [15:0]  grant_cnt;
  logic [3:0]   max_wait;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mesh_term_rr_arbiter #(
    .N_REQ(4),
    .pckg_sz(32)
`ifdef MESH_ARB_GRANT_STATS_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .pndng_req(pndng_req),
    .data_req(data_req),
    .pop_req(pop_req),
    .pndng_o(pndng_o),
    .data_o(data_o),
    .pop_i(pop_i),
    .gnt_idx_o(gnt_idx_o),
    .protocol_err(protocol_err)
`ifdef MESH_ARB_GRANT_STATS_EN
    , .grant_cnt(grant_cnt),
    .max_wait(max_wait)
`endif
  );

  localparam logic [127:0] ALL_DATA = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    pndng_req = 4'b0000;
    pop_i     = 1'b0;
    data_req  = '0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    pndng_req = 4'b1111;
    data_req  = ALL_DATA;
    pop_i     = 1'b0;
    step();
    step();
    n_checks++; if (pop_req !== 4'b0000) begin n_errors++; $display("FAIL reset_pop_req actual=%b required=%b", pop_req, 4'b0000); end
    n_checks++; if (pndng_o !== 1'b0) begin n_errors++; $display("FAIL reset_pndng actual=%b required=%b", pndng_o, 1'b0); end
    n_checks++; if (data_o !== 32'h0) begin n_errors++; $display("FAIL reset_data actual=%h required=%h", data_o, 32'h0); end
    n_checks++; if (gnt_idx_o !== 2'd0) begin n_errors++; $display("FAIL reset_gnt actual=%0d required=%0d", gnt_idx_o, 0); end
    n_checks++; if (protocol_err !== 1'b0) begin n_errors++; $display("FAIL reset_perr actual=%b required=%b", protocol_err, 1'b0); end
    pndng_req = 4'b0000;
    reset     = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    pndng_req        = 4'b0100;
    data_req[95:64]  = 32'hA5A5_0002;
    #1;
    n_checks++; if (pop_req !== 4'b0100) begin n_errors++; $display("FAIL single_pop actual=%b required=%b", pop_req, 4'b0100); end
    n_checks++; if (pndng_o !== 1'b0) begin n_errors++; $display("FAIL single_c0_pndng actual=%b required=%b", pndng_o, 1'b0); end
    step();
    pndng_req = 4'b0000;
    for (int c = 1; c <= 3; c++) begin
      pop_i = (c == 3);
      #1;
      n_checks++; if (pndng_o !== 1'b1) begin n_errors++; $display("FAIL single_pndng c%0d actual=%b required=%b", c, pndng_o, 1'b1); end
      n_checks++; if (data_o !== 32'hA5A5_0002) begin n_errors++; $display("FAIL single_data c%0d actual=%h required=%h", c, data_o, 32'hA5A5_0002); end
      n_checks++; if (gnt_idx_o !== 2'd2) begin n_errors++; $display("FAIL single_gnt c%0d actual=%0d required=%0d", c, gnt_idx_o, 2); end
      n_checks++; if (pop_req !== 4'b0000) begin n_errors++; $display("FAIL single_nopop c%0d actual=%b required=%b", c, pop_req, 4'b0000); end
      step();
    end
    pop_i = 1'b0;
    #1;
    n_checks++; if (pndng_o !== 1'b0) begin n_errors++; $display("FAIL single_c4_pndng actual=%b required=%b", pndng_o, 1'b0); end
    n_checks++; if (protocol_err !== 1'b0) begin n_errors++; $display("FAIL single_perr actual=%b required=%b", protocol_err, 1'b0); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_pop;
    logic [31:0] exp_data;
    logic [1:0]  exp_gnt;
    apply_reset();
    data_req  = ALL_DATA;
    pndng_req = 4'b1111;
    #1;
    n_checks++; if (pop_req !== 4'b0001) begin n_errors++; $display("FAIL rr_first_pop actual=%b required=%b", pop_req, 4'b0001); end
    step();
    pop_i = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      exp_pop  = 4'(1 << (c % 4));
      exp_gnt  = 2'((c - 1) % 4);
      exp_data = 32'hD000_0000 + 32'((c - 1) % 4);
      #1;
      n_checks++; if (pop_req !== exp_pop) begin n_errors++; $display("FAIL rr_pop c%0d actual=%b required=%b", c, pop_req, exp_pop); end
      n_checks++; if (pndng_o !== 1'b1) begin n_errors++; $display("FAIL rr_pndng c%0d actual=%b required=%b", c, pndng_o, 1'b1); end
      n_checks++; if (data_o !== exp_data) begin n_errors++; $display("FAIL rr_data c%0d actual=%h required=%h", c, data_o, exp_data); end
      n_checks++; if (gnt_idx_o !== exp_gnt) begin n_errors++; $display("FAIL rr_gnt c%0d actual=%0d required=%0d", c, gnt_idx_o, exp_gnt); end
      step();
    end
    pop_i     = 1'b0;
    pndng_req = 4'b0000;
    n_checks++; if (protocol_err !== 1'b0) begin n_errors++; $display("FAIL rr_perr actual=%b required=%b", protocol_err, 1'b0); end
  endtask

  task automatic test_stall();
    apply_reset();
    data_req  = ALL_DATA;
    pndng_req = 4'b1111;
    #1;
    n_checks++; if (pop_req !== 4'b0001) begin n_errors++; $display("FAIL stall_first_pop actual=%b required=%b", pop_req, 4'b0001); end
    step();
    for (int c = 1; c <= 10; c++) begin
      #1;
      n_checks++; if (pop_req !== 4'b0000) begin n_errors++; $display("FAIL stall_pop c%0d actual=%b required=%b", c, pop_req, 4'b0000); end
      n_checks++; if (pndng_o !== 1'b1) begin n_errors++; $display("FAIL stall_pndng c%0d actual=%b required=%b", c, pndng_o, 1'b1); end
      n_checks++; if (data_o !== 32'hD000_0000) begin n_errors++; $display("FAIL stall_data c%0d actual=%h required=%h", c, data_o, 32'hD000_0000); end
      n_checks++; if (gnt_idx_o !== 2'd0) begin n_errors++; $display("FAIL stall_gnt c%0d actual=%0d required=%0d", c, gnt_idx_o, 0); end
      step();
    end
    pop_i = 1'b1;
    #1;
    n_checks++; if (pop_req !== 4'b0010) begin n_errors++; $display("FAIL stall_release_pop actual=%b required=%b", pop_req, 4'b0010); end
    step();
    pop_i     = 1'b0;
    pndng_req = 4'b0000;
    #1;
    n_checks++; if (data_o !== 32'hD000_0001) begin n_errors++; $display("FAIL stall_next_data actual=%h required=%h", data_o, 32'hD000_0001); end
    n_checks++; if (gnt_idx_o !== 2'd1) begin n_errors++; $display("FAIL stall_next_gnt actual=%0d required=%0d", gnt_idx_o, 1); end
  endtask

  task automatic test_protocol_err();
    apply_reset();
    pop_i = 1'b1;
    #1;
    n_checks++; if (pop_req !== 4'b0000) begin n_errors++; $display("FAIL perr_pop actual=%b required=%b", pop_req, 4'b0000); end
    step();
    pop_i = 1'b0;
    #1;
    n_checks++; if (protocol_err !== 1'b1) begin n_errors++; $display("FAIL perr_set actual=%b required=%b", protocol_err, 1'b1); end
    n_checks++; if (pndng_o !== 1'b0) begin n_errors++; $display("FAIL perr_pndng actual=%b required=%b", pndng_o, 1'b0); end
    step();
    step();
    step();
    n_checks++; if (protocol_err !== 1'b1) begin n_errors++; $display("FAIL perr_sticky actual=%b required=%b", protocol_err, 1'b1); end
    apply_reset();
    n_checks++; if (protocol_err !== 1'b0) begin n_errors++; $display("FAIL perr_cleared actual=%b required=%b", protocol_err, 1'b0); end
  endtask

  task automatic test_reset_mid_send();
    apply_reset();
    pndng_req       = 4'b0100;
    data_req[95:64] = 32'hA5A5_0002;
    step();
    pndng_req = 4'b0000;
    #1;
    n_checks++; if (pndng_o !== 1'b1) begin n_errors++; $display("FAIL midrst_send actual=%b required=%b", pndng_o, 1'b1); end
    reset = 1'b0;
    #1;
    n_checks++; if (pndng_o !== 1'b0) begin n_errors++; $display("FAIL midrst_async_pndng actual=%b required=%b", pndng_o, 1'b0); end
    n_checks++; if (data_o !== 32'h0) begin n_errors++; $display("FAIL midrst_async_data actual=%h required=%h", data_o, 32'h0); end
    step();
    reset     = 1'b1;
    data_req  = ALL_DATA;
    pndng_req = 4'b1111;
    #1;
    n_checks++; if (pop_req !== 4'b0001) begin n_errors++; $display("FAIL midrst_first_pop actual=%b required=%b", pop_req, 4'b0001); end
    step();
    pndng_req = 4'b0000;
    #1;
    n_checks++; if (gnt_idx_o !== 2'd0) begin n_errors++; $display("FAIL midrst_gnt actual=%0d required=%0d", gnt_idx_o, 0); end
    n_checks++; if (data_o !== 32'hD000_0000) begin n_errors++; $display("FAIL midrst_data actual=%h required=%h", data_o, 32'hD000_0000); end
  endtask

`ifdef MESH_ARB_GRANT_STATS_EN
  task automatic test_stats();
    apply_reset();
    data_req  = ALL_DATA;
    pndng_req = 4'b0010;
    step();
    pop_i = 1'b1;
    for (int c = 1; c < 20; c++) begin
      step();
    end
    pndng_req = 4'b0000;
    #1;
    n_checks++; if (grant_cnt[7:4] !== 4'hF) begin n_errors++; $display("FAIL stats_cnt1 actual=%h required=%h", grant_cnt[7:4], 4'hF); end
    n_checks++; if (grant_cnt[3:0] !== 4'h0) begin n_errors++; $display("FAIL stats_cnt0 actual=%h required=%h", grant_cnt[3:0], 4'h0); end
    n_checks++; if (max_wait !== 4'h0) begin n_errors++; $display("FAIL stats_max_wait actual=%h required=%h", max_wait, 4'h0); end
    step();
    pop_i = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    pndng_req = 4'b0000;
    data_req  = '0;
    pop_i     = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_protocol_err();
    test_reset_mid_send();
`ifdef MESH_ARB_GRANT_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
